// File: rtl/switch_gen_pkg.sv
// Shared definitions for the switch stimulus blocks: FSM encoding and LFSR feedback taps.
package switch_gen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBounce,
        StSettle
    } state_e;

    // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting Fibonacci register.
    localparam logic [15:0] LfsrTaps = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; holds its seed while reset is high.
module lfsr16
    import switch_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical switch model: turns a clean level request into a pseudo-random bounce burst,
// a change strobe, a settle interval and a done pulse.
module switch_bounce_gen
    import switch_gen_pkg::*;
#(
    parameter int unsigned BC_W          = 2,
    parameter int unsigned SEG_W         = 3,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic target,
    output logic sig_out,
    output logic sig_change,
    output logic busy,
    output logic done
);

    localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

    logic [15:0] lfsr;
    logic        unused_lfsr;
    logic [SEG_W:0] seg_len;

    state_e          state_q, state_d;
    logic            stable_q, stable_d;
    logic            old_q, old_d;
    logic            tgt_q, tgt_d;
    logic            phase_q, phase_d;
    logic [BC_W-1:0] k_q, k_d;
    logic [SEG_W:0]  seg_cnt_q, seg_cnt_d;
    logic [SetW-1:0] set_cnt_q, set_cnt_d;
    logic            sig_out_q, sig_out_d;
    logic            sig_change_q, sig_change_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    // Only a few LFSR fields are consumed.
    assign unused_lfsr = ^lfsr;
    assign seg_len     = {1'b0, lfsr[SEG_W+7:8]} + (SEG_W + 1)'(1);

    always_comb begin
        state_d      = state_q;
        stable_d     = stable_q;
        old_d        = old_q;
        tgt_d        = tgt_q;
        phase_d      = phase_q;
        k_d          = k_q;
        seg_cnt_d    = seg_cnt_q;
        set_cnt_d    = set_cnt_q;
        sig_out_d    = sig_out_q;
        sig_change_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                sig_out_d = stable_q;
                if (target != stable_q) begin
                    old_d        = stable_q;
                    tgt_d        = target;
                    k_d          = lfsr[BC_W-1:0];
                    seg_cnt_d    = seg_len;
                    phase_d      = 1'b0;
                    sig_out_d    = target;
                    sig_change_d = 1'b1;
                    state_d      = StBounce;
                end
            end
            StBounce: begin
                if (seg_cnt_q > (SEG_W + 1)'(1)) begin
                    seg_cnt_d = seg_cnt_q - (SEG_W + 1)'(1);
                end else if (!phase_q) begin
                    // A target segment ends: either the final one or the first half of a pair.
                    if (k_q == '0) begin
                        state_d   = StSettle;
                        set_cnt_d = SetW'(SETTLE_CYCLES);
                    end else begin
                        phase_d   = 1'b1;
                        seg_cnt_d = seg_len;
                        sig_out_d = old_q;
                    end
                end else begin
                    phase_d   = 1'b0;
                    k_d       = k_q - BC_W'(1);
                    seg_cnt_d = seg_len;
                    sig_out_d = tgt_q;
                end
            end
            StSettle: begin
                if (set_cnt_q > SetW'(1)) begin
                    set_cnt_d = set_cnt_q - SetW'(1);
                end else begin
                    state_d  = StIdle;
                    stable_d = tgt_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        // Registered done must coincide with the last settle cycle.
        done_d = (state_d == StSettle) && (set_cnt_d == SetW'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            stable_q     <= 1'b0;
            old_q        <= 1'b0;
            tgt_q        <= 1'b0;
            phase_q      <= 1'b0;
            k_q          <= '0;
            seg_cnt_q    <= '0;
            set_cnt_q    <= '0;
            sig_out_q    <= 1'b0;
            sig_change_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stable_q     <= stable_d;
            old_q        <= old_d;
            tgt_q        <= tgt_d;
            phase_q      <= phase_d;
            k_q          <= k_d;
            seg_cnt_q    <= seg_cnt_d;
            set_cnt_q    <= set_cnt_d;
            sig_out_q    <= sig_out_d;
            sig_change_q <= sig_change_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sig_out    = sig_out_q;
    assign sig_change = sig_change_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen: default instance plus a BC_W=1 instance for clean edges,
// with a small debouncer closing the loop on the default instance.
module tb_switch_bounce_gen;

    localparam logic [15:0] SeedA = 16'hACE1;
    localparam logic [15:0] SeedB = 16'h1234;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ta = 1'b0;
    logic tb_t = 1'b0;
    logic so_a, sc_a, busy_a, done_a;
    logic so_b, sc_b, busy_b, done_b;
    logic [15:0] m_a, m_b;
    logic db;
    logic [3:0] dcnt;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    switch_bounce_gen dut_a (
        .clk        (clk),
        .reset      (reset),
        .target     (ta),
        .sig_out    (so_a),
        .sig_change (sc_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    switch_bounce_gen #(
        .BC_W      (1),
        .LFSR_SEED (SeedB)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .target     (tb_t),
        .sig_out    (so_b),
        .sig_change (sc_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSRs running in lockstep with the DUTs.
    always @(posedge clk) begin
        if (reset) begin
            m_a <= SeedA;
            m_b <= SeedB;
        end else begin
            m_a <= lfsr_step(m_a);
            m_b <= lfsr_step(m_b);
        end
    end

    // Debouncer: needs 16 consecutive differing cycles; a change strobe restarts the count.
    always @(posedge clk) begin
        if (reset) begin
            db   <= 1'b0;
            dcnt <= 4'd0;
        end else if (sc_a || so_a == db) begin
            dcnt <= 4'd0;
        end else if (dcnt == 4'd15) begin
            db   <= so_a;
            dcnt <= 4'd0;
        end else begin
            dcnt <= dcnt + 4'd1;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input bit sel, output logic so, output logic sc, output logic bz,
                        output logic dn);
        so = sel ? so_b : so_a;
        sc = sel ? sc_b : sc_a;
        bz = sel ? busy_b : busy_a;
        dn = sel ? done_b : done_a;
    endtask

    // Called in an idle cycle; returns one cycle after done with dur = done cycle - start edge.
    task automatic transition(input bit sel, input logic lvl, input int toggle_at, output int dur);
        logic [15:0] s;
        logic so, sc, bz, dn, prev, prev_db;
        int k, seg1, edges, run, cyc, chg, db_edges, first_edge;
        bit seen;
        s    = sel ? m_b : m_a;
        k    = sel ? int'(s[0]) : int'(s[1:0]);
        seg1 = int'(s[10:8]) + 1;
        snap(sel, so, sc, bz, dn);
        check_val("idle_busy", int'(bz), 0);
        check_val("pre_level", int'(so), int'(!lvl));
        prev    = so;
        prev_db = db;
        if (sel) tb_t = lvl; else ta = lvl;
        tick();
        snap(sel, so, sc, bz, dn);
        check_val("start_change", int'(sc), 1);
        check_val("start_busy", int'(bz), 1);
        check_val("start_level", int'(so), int'(lvl));
        edges = (so != prev) ? 1 : 0;
        prev = so;
        run = 1;
        cyc = 1;
        chg = 0;
        db_edges = 0;
        first_edge = 0;
        seen = 0;
        while (!seen && cyc < 400) begin
            if (cyc == toggle_at) begin
                if (sel) tb_t = !lvl; else ta = !lvl;
            end
            tick();
            cyc++;
            snap(sel, so, sc, bz, dn);
            if (sc) chg++;
            if (so != prev) begin
                edges++;
                run = 1;
                if (edges == 2) first_edge = cyc;
            end else begin
                run++;
            end
            prev = so;
            if (db != prev_db) db_edges++;
            prev_db = db;
            if (dn) begin
                seen = 1;
                check_val("done_busy", int'(bz), 1);
            end
        end
        dur = cyc;
        check_val("done_seen", int'(seen), 1);
        check_val("extra_change", chg, 0);
        check_val("edge_count", edges, 2 * k + 1);
        check_val("settled_run", int'(run >= 64), 1);
        check_val("final_level", int'(prev), int'(lvl));
        check_val("dur_bound", int'(dur <= (2 * k + 1) * 8 + 64), 1);
        if (k > 0) check_val("first_seg", first_edge, seg1 + 1);
        if (!sel) begin
            check_val("loop_db_edges", db_edges, 1);
            check_val("loop_db_level", int'(db), int'(lvl));
        end
        tick();
        snap(sel, so, sc, bz, dn);
        check_val("post_busy", int'(bz), 0);
        check_val("post_done", int'(dn), 0);
        check_val("post_change", int'(sc), 0);
        check_val("post_level", int'(so), int'(lvl));
    endtask

    initial begin
        int dur, exp_dur, w, n_sc, n_dn, n_bz, n_so;
        repeat (3) tick();
        check_val("rst_sig_out", int'(so_a), 0);
        check_val("rst_change", int'(sc_a), 0);
        check_val("rst_busy", int'(busy_a), 0);
        check_val("rst_done", int'(done_a), 0);
        check_val("rst_lfsr", int'(dut_a.u_lfsr.q), int'(SeedA));
        reset = 1'b0;

        // Idle hold
        n_sc = 0; n_dn = 0; n_bz = 0; n_so = 0;
        repeat (200) begin
            tick();
            n_sc += int'(sc_a | sc_b);
            n_dn += int'(done_a | done_b);
            n_bz += int'(busy_a | busy_b);
            n_so += int'(so_a | so_b);
        end
        check_val("idle_changes", n_sc, 0);
        check_val("idle_dones", n_dn, 0);
        check_val("idle_busy_cnt", n_bz, 0);
        check_val("idle_high_cnt", n_so, 0);
        check_val("lfsr_track", int'(dut_a.u_lfsr.q), int'(m_a));

        // Single transition 0->1
        transition(1'b0, 1'b1, -1, dur);

        // Clean edge on the BC_W=1 instance
        w = 0;
        while (m_b[0] != 1'b0 && w < 50) begin
            tick();
            w++;
        end
        check_val("k0_found", int'(m_b[0]), 0);
        exp_dur = int'(m_b[10:8]) + 1 + 64;
        transition(1'b1, 1'b1, -1, dur);
        check_val("clean_dur", dur, exp_dur);

        // Target change while busy, then immediate follow-up transition
        transition(1'b0, 1'b0, -1, dur);
        transition(1'b0, 1'b1, 1, dur);
        check_val("retarget_pending", int'(ta), 0);
        transition(1'b0, 1'b0, -1, dur);

        // Reset during SETTLE: cycle N+57 is always past the longest bounce burst
        ta = 1'b1;
        tick();
        check_val("rst_test_start", int'(sc_a), 1);
        repeat (56) tick();
        check_val("rst_test_busy", int'(busy_a), 1);
        reset = 1'b1;
        ta = 1'b0;
        tick();
        check_val("mid_rst_sig_out", int'(so_a), 0);
        check_val("mid_rst_busy", int'(busy_a), 0);
        check_val("mid_rst_done", int'(done_a), 0);
        check_val("mid_rst_change", int'(sc_a), 0);
        check_val("mid_rst_lfsr", int'(dut_a.u_lfsr.q), int'(SeedA));
        reset = 1'b0;
        n_sc = 0; n_dn = 0;
        repeat (100) begin
            tick();
            n_sc += int'(sc_a);
            n_dn += int'(done_a);
        end
        check_val("after_rst_dones", n_dn, 0);
        check_val("after_rst_changes", n_sc, 0);

        // Closed loop through the debouncer
        transition(1'b0, 1'b1, -1, dur);
        transition(1'b0, 1'b0, -1, dur);
        transition(1'b0, 1'b1, -1, dur);
        check_val("loop_final", int'(db), int'(ta));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_bounce_gen.md
# switch_bounce_gen

Synthesizable model of a mechanical switch. It converts a clean requested switch level into a realistically bouncing signal plus a change strobe, then settles on the requested level. It is the driving end of the debouncer interface (`sig_in` / `sig_change`). It is used for on-board self-test and closed-loop benches of the debounce chain. Bounce pattern lengths are pseudo-random from a free-running 16-bit LFSR, so every run is repeatable for a given seed.

## Interface
- `BC_W`, default 2: width of the bounce-pair count field; k ranges 0..2^BC_W−1.
- `SEG_W`, default 3: width of the segment-length field; each segment lasts 1..2^SEG_W cycles.
- `SETTLE_CYCLES`, default 64: cycles the final level is held before completion; must be ≥1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`, input, 1: single clock; every register is on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `target`, input, 1: requested clean switch level.
- `sig_out`, output, 1: bouncing switch signal; this drives the debouncer's `sig_in`.
- `sig_change`, output, 1: one-cycle strobe at the start of a transition; this drives the debouncer's `sig_change`.
- `busy`, output, 1: high from transition start until the done pulse, inclusive.
- `done`, output, 1: one-cycle pulse when the settle phase ends.

## Operation
- Internal state:
  - `stable`: last settled level.
  - `old`: level before the current transition.
  - `k`: remaining glitch pairs.
  - `seg_cnt`: remaining cycles in the current segment.
  - `set_cnt`: settle counter.
  - `phase`: selects the target or old level within a pair.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left.
  - Advances every cycle, including during IDLE; it holds only while `reset` is high.
- State IDLE:
  - `sig_out` = `stable`; `busy` = 0.
  - If `target` ≠ `stable`: latch `old` = `stable`, latch `k` = lfsr[BC_W-1:0], load the first segment length from lfsr[SEG_W+7:8]+1, go to BOUNCE.
- State BOUNCE:
  - Drives `target` (latched value) for one segment, then `old` for one segment. That is one pair; the pair repeats k times.
  - A final segment of `target` follows, so 2k+1 segments in total.
  - Each new segment length is lfsr[SEG_W+7:8]+1, sampled on the last cycle of the previous segment.
  - After the final segment, go to SETTLE.
- State SETTLE:
  - `sig_out` = `target` for SETTLE_CYCLES cycles.
  - On the last cycle: `done` = 1, `stable` ← target, go to IDLE.
- `target` is latched at transition start. Changes to `target` during BOUNCE or SETTLE are ignored.
- After returning to IDLE, a still-different `target` starts a new transition on the next evaluation.
- k = 0 gives a clean edge: one segment, then settle.

## Timing
- Reset values: `sig_out` = 0, `sig_change` = 0, `busy` = 0, `done` = 0, `stable` = 0, LFSR = LFSR_SEED, state IDLE.
- Latency:
  - `target` ≠ `stable` sampled at edge N.
  - At cycle N+1: `sig_out` = new level, `sig_change` = 1 (this cycle only), `busy` = 1.
- All outputs are registered; nothing combinational runs from `target` to any output.
- Total transition length = Σ(segment lengths) + SETTLE_CYCLES, bounded by (2k+1)·2^SEG_W + SETTLE_CYCLES.
- Cycle after `done`: `busy` = 0. If `target` still differs, the earliest next `sig_change` is 2 cycles after `done`.
- Reset mid-BOUNCE or mid-SETTLE: immediate return to the reset values. No `done` and no `sig_change` are emitted.
- Counters never wrap. `seg_cnt` is SEG_W+1 bits; `set_cnt` is sized to $clog2(SETTLE_CYCLES+1).

## Structure
- Shared package `switch_gen_pkg`: state encoding (IDLE, BOUNCE, SETTLE) and the LFSR tap constant 16'hB400.
- Sub-module `lfsr16`: ports `clk`, `reset`, seed parameter, and 16-bit `q`. It is reusable by other stimulus blocks.
- The top level holds the FSM, the counters and the output registers.

## Test plan
- **Idle hold:** reset, `target` = 0 for 200 cycles → `sig_out` = 0, `busy` = 0, no `sig_change` and no `done` throughout.
- **Single transition:** defaults, `target` 0→1 → `sig_change` exactly once at N+1.
  - The `sig_out` edge count equals 2k+1, with k matching the LFSR reference model.
  - `sig_out` = 1 for the last 64 cycles before `done`.
  - `stable` = 1 afterwards.
- **Clean edge:** BC_W=1 and a seed whose field gives k = 0 → exactly one `sig_out` edge, `done` at N+seg+64.
- **Target change while busy:** toggle `target` 1→0 mid-BOUNCE → the pattern completes to 1 and `done` fires. A second transition to 0 then starts 2 cycles after `done`.
- **Reset mid-operation:** assert `reset` during SETTLE → next cycle `sig_out` = 0, `busy` = 0, LFSR = seed, and no `done` that cycle or after.
- **Closed loop:** `sig_out` and `sig_change` drive the debouncer (`sig_in`, `sig_change`) → the debounced output changes exactly once per transition and ends at `target`.
